single_argmax: RTL and testbench



---
 rtl/single_argmax.sv | 118 +++++++++++
 tb/tb_single_argmax.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/single_argmax.sv
// Streaming max/argmax reducer for single-precision float vectors.
// Reduces one in_last-delimited vector to a single held result beat.
module single_argmax #(
  parameter int IDX_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_max,
  output logic [IDX_W-1:0]   out_idx,
  output logic [IDX_W:0]     out_count,
  output logic               out_overflow
);

  localparam logic [1:0] S_FIRST = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [IDX_W:0] CNT_MAX = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [31:0]      max_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W:0]   cnt_r;
  logic             ovf_r;
  logic             in_ready_r;

  logic accept;
  logic take;

  // Sign-magnitude ordering; +0 and -0 are equal, NaN/Inf ordered by bits.
  function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
    logic res;
    if (a[31] != b[31])
      res = !a[31] && ((a[30:0] != 31'd0) || (b[30:0] != 31'd0));
    else if (!a[31])
      res = a[30:0] > b[30:0];
    else
      res = a[30:0] < b[30:0];
    return res;
  endfunction

  assign accept = in_valid && in_ready_r && (state_r != S_DONE);
  assign take   = gt(in_data, max_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_FIRST;
      max_r      <= 32'd0;
      idx_r      <= '0;
      cnt_r      <= '0;
      ovf_r      <= 1'b0;
      in_ready_r <= 1'b0;
    end else begin
      case (state_r)
        S_FIRST: begin
          if (accept) begin
            max_r <= in_data;
            idx_r <= '0;
            cnt_r <= CNT_ONE;
            ovf_r <= 1'b0;
            if (in_last) begin
              state_r    <= S_DONE;
              in_ready_r <= 1'b0;
            end else begin
              state_r <= S_ACC;
            end
          end else if (!in_ready_r) begin
            // First edge after reset release.
            in_ready_r <= 1'b1;
          end
        end
        S_ACC: begin
          if (accept) begin
            if (cnt_r != CNT_MAX) begin
              if (take) begin
                max_r <= in_data;
                idx_r <= cnt_r[IDX_W-1:0];
              end
              cnt_r <= cnt_r + CNT_ONE;
            end else begin
              // Beyond capacity: drop the beat, keep the count saturated.
              ovf_r <= 1'b1;
            end
            if (in_last) begin
              state_r    <= S_DONE;
              in_ready_r <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_r    <= S_FIRST;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= S_FIRST;
          in_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = (state_r == S_DONE);
  assign out_max      = max_r;
  assign out_idx      = idx_r;
  assign out_count    = cnt_r;
  assign out_overflow = ovf_r;

endmodule

// File: tb/tb_single_argmax.sv
// Randomized and directed bench for single_argmax against a signed-key reference model.
module tb_single_argmax;
  localparam int IDX_W = 2;
  localparam int CAP = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = 32'd0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_max;
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W:0]   out_count;
  logic             out_overflow;

  int total = 0;
  int bad = 0;
  logic [31:0] vec[$];

  single_argmax #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_idx(out_idx), .out_count(out_count), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Float as a signed integer on the real line: both zeros map to 0.
  function automatic longint key(input logic [31:0] f);
    longint m;
    m = longint'({1'b0, f[30:0]});
    return f[31] ? -m : m;
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic last);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_max"}, out_max, 32'd0);
    check({tag, "_out_idx"}, 32'(out_idx), 32'd0);
    check({tag, "_out_count"}, 32'(out_count), 32'd0);
    check({tag, "_out_ovf"}, 32'(out_overflow), 32'd0);
  endtask

  task automatic run_vec(input string name, input int hold, input bit fixed,
                         input logic [31:0] fmax, input int fidx, input int fcnt, input bit fovf);
    logic [31:0] emax;
    int eidx, ecnt, n;
    bit eovf;
    n = vec.size();
    emax = vec[0];
    eidx = 0;
    for (int i = 1; i < n && i < CAP; i++)
      if (key(vec[i]) > key(emax)) begin
        emax = vec[i];
        eidx = i;
      end
    ecnt = (n < CAP) ? n : CAP;
    eovf = (n > CAP);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      send_beat(vec[i], i == n - 1);
    end
    // One cycle after the last accept.
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_max"}, out_max, emax);
    check({name, "_idx"}, 32'(out_idx), 32'(eidx));
    check({name, "_count"}, 32'(out_count), 32'(ecnt));
    check({name, "_ovf"}, 32'(out_overflow), 32'(eovf));
    if (fixed) begin
      check({name, "_max_fixed"}, out_max, fmax);
      check({name, "_idx_fixed"}, 32'(out_idx), 32'(fidx));
      check({name, "_count_fixed"}, 32'(out_count), 32'(fcnt));
      check({name, "_ovf_fixed"}, 32'(out_overflow), 32'(fovf));
    end
    for (int h = 0; h <= hold; h++) begin
      check({name, "_hold_ready"}, 32'(in_ready), 32'd0);
      check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({name, "_hold_max"}, out_max, emax);
      check({name, "_hold_idx"}, 32'(out_idx), 32'(eidx));
      if (h < hold) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_post_valid"}, 32'(out_valid), 32'd0);
    check({name, "_post_ready"}, 32'(in_ready), 32'd1);
    $display("vec %s n=%0d max=%h idx=%0d count=%0d ovf=%0d", name, n, out_max, eidx, ecnt, eovf);
  endtask

  initial begin
    logic [31:0] d;
    // Reset state.
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release_ready", 32'(in_ready), 32'd1);

    vec = '{32'h3F800000, 32'h40000000, 32'h3F000000};
    run_vec("positive", 0, 1'b1, 32'h40000000, 1, 3, 1'b0);
    vec = '{32'hC0000000, 32'hBF800000, 32'hC0400000};
    run_vec("negative", 1, 1'b1, 32'hBF800000, 1, 3, 1'b0);
    vec = '{32'h80000000, 32'h00000000};
    run_vec("zeros", 0, 1'b1, 32'h80000000, 0, 2, 1'b0);
    vec = '{32'h00000000, 32'h3F800000, 32'h3F800000};
    run_vec("tie", 0, 1'b1, 32'h3F800000, 1, 3, 1'b0);
    vec = '{32'h41200000};
    run_vec("single_bp", 5, 1'b1, 32'h41200000, 0, 1, 1'b0);
    vec = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F000000, 32'h41100000, 32'h41000000};
    run_vec("overflow", 0, 1'b1, 32'h40400000, 1, 4, 1'b1);

    // Reset mid-vector after 2 of 4 beats.
    send_beat(32'h42000000, 1'b0);
    send_beat(32'h42800000, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("midrst_ready_high", 32'(in_ready), 32'd1);
    vec = '{32'h3F800000, 32'h40A00000};
    run_vec("after_rst", 0, 1'b1, 32'h40A00000, 1, 2, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int n;
      n = $urandom_range(1, 7);
      vec = {};
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 4))
          0: d = 32'h00000000;
          1: d = 32'h80000000;
          2: d = (i > 0) ? vec[i-1] : $urandom;
          default: d = $urandom;
        endcase
        vec.push_back(d);
      end
      run_vec($sformatf("rand%0d", t), $urandom_range(0, 3), 1'b0, 32'd0, 0, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
